// File: rtl/calc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer_if
// Purpose  : Instruction-side bundle of the calculator sequencer. It carries
//            the valid/ready issue handshake with the decoded three-address
//            fields, and the completion strobe with its result and overflow.
// Ports    : master drives in_valid/op/rd/rs/rt/imm and observes
//            in_ready/done/result/ovf; slave is the sequencer side.
// Revision : 1.0  initial release
// ============================================================================
interface calc_sequencer_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [AW-1:0] rd;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [DW-1:0] imm;
  logic          done;
  logic [DW-1:0] result;
  logic          ovf;

  modport master (
    output in_valid, op, rd, rs, rt, imm,
    input  in_ready, done, result, ovf
  );

  modport slave (
    input  in_valid, op, rd, rs, rt, imm,
    output in_ready, done, result, ovf
  );
endinterface
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Multi-cycle ALU sequencer acting as the only master of an 8x8
//            register file. One instruction at a time: read both sources,
//            execute (multiply is an 8-cycle shift-add), write back.
// Ports    : Clk, Rst        clock, synchronous active-high reset
//            cpu (slave)     instruction handshake and completion/result
//            RX, RY          register-file read addresses
//            busX, busY      register-file combinational read data
//            WEN, RW, busW   register-file write enable/address/data
// Revision : 1.0  initial release
// ============================================================================
module calc_sequencer #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  wire            Clk,
  input  wire            Rst,
  calc_sequencer_if.slave cpu,
  output logic [AW-1:0]  RX,
  output logic [AW-1:0]  RY,
  input  wire  [DW-1:0]  busX,
  input  wire  [DW-1:0]  busY,
  output logic           WEN,
  output logic [AW-1:0]  RW,
  output logic [DW-1:0]  busW
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    MUL  = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_d;

  // Captured instruction
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] imm_q;

  // Operands; during MUL these double as the shifting multiplicand/multiplier
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] acc;
  logic [7:0]    cnt;

  logic          done_q;
  logic          ovf_q;
  logic [DW-1:0] result_q;

  logic          xfer;
  logic [DW-1:0] sum;
  logic [DW-1:0] diff;
  logic [DW-1:0] acc_next;
  logic [DW-1:0] alu;
  logic          alu_ovf;
  logic          load_wb;
  logic [DW-1:0] wb_val;
  logic          wb_ovf;

  assign cpu.in_ready = (state == IDLE) && !Rst;
  assign cpu.done     = done_q;
  assign cpu.result   = result_q;
  assign cpu.ovf      = ovf_q;

  assign xfer     = cpu.in_valid && cpu.in_ready;
  assign sum      = opa + opb;
  assign diff     = opa - opb;
  assign acc_next = opb[0] ? (acc + opa) : acc;

  // Single-cycle operations; MUL is produced by the iterative path instead
  always_comb begin
    alu     = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu     = sum;
        alu_ovf = (opa[DW-1] == opb[DW-1]) && (sum[DW-1] != opa[DW-1]);
      end
      OP_SUB: begin
        alu     = diff;
        alu_ovf = (opa[DW-1] != opb[DW-1]) && (diff[DW-1] != opa[DW-1]);
      end
      OP_AND: alu = opa & opb;
      OP_OR:  alu = opa | opb;
      OP_XOR: alu = opa ^ opb;
      OP_SLT: alu = {{(DW-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_LDI: alu = imm_q;
      default: alu = '0;
    endcase
  end

  // Next state, plus the strobe that loads the registered write-back outputs
  // on the edge entering WB so they are all valid throughout the WB cycle.
  always_comb begin
    state_d = state;
    load_wb = 1'b0;
    wb_val  = '0;
    wb_ovf  = 1'b0;
    case (state)
      IDLE: if (xfer) state_d = READ;
      READ: state_d = (op_q == OP_MUL) ? MUL : EXEC;
      EXEC: begin
        state_d = WB;
        load_wb = 1'b1;
        wb_val  = alu;
        wb_ovf  = alu_ovf;
      end
      MUL: begin
        if (cnt == 8'd7) begin
          state_d = WB;
          load_wb = 1'b1;
          wb_val  = acc_next;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      RX       <= '0;
      RY       <= '0;
      WEN      <= 1'b0;
      RW       <= '0;
      busW     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // Bus strobes last a single cycle; result/ovf hold until the next WB
      RX     <= '0;
      RY     <= '0;
      WEN    <= 1'b0;
      RW     <= '0;
      busW   <= '0;
      done_q <= 1'b0;

      if (xfer) begin
        op_q  <= cpu.op;
        rd_q  <= cpu.rd;
        imm_q <= cpu.imm;
        // Read addresses are registered here so they are stable during READ
        RX    <= cpu.rs;
        RY    <= cpu.rt;
      end

      if (state == READ) begin
        opa <= busX;
        opb <= busY;
        acc <= '0;
        cnt <= '0;
      end

      if (state == MUL) begin
        acc <= acc_next;
        opa <= opa << 1;
        opb <= opb >> 1;
        cnt <= cnt + 8'd1;
      end

      if (load_wb) begin
        // Register 0 is hard zero, so its write is suppressed
        WEN      <= (rd_q != '0);
        RW       <= rd_q;
        busW     <= wb_val;
        done_q   <= 1'b1;
        result_q <= wb_val;
        ovf_q    <= wb_ovf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_sequencer
// Purpose  : Self-checking bench for calc_sequencer with a behavioural 8x8
//            register file and a scoreboard of expected write-backs.
// Revision : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [2:0] RX, RY, RW;
  logic [7:0] busX, busY, busW;
  logic       WEN;
  logic [7:0] rf [8] = '{default: 8'h00};

  calc_sequencer_if #(.DW(8), .AW(3)) cpu ();

  calc_sequencer #(.DW(8), .AW(3)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .cpu  (cpu),
    .RX   (RX),
    .RY   (RY),
    .busX (busX),
    .busY (busY),
    .WEN  (WEN),
    .RW   (RW),
    .busW (busW)
  );

  always #5 Clk = ~Clk;

  // Behavioural register file: combinational reads, write at the rising edge
  assign busX = rf[RX];
  assign busY = rf[RY];
  always @(posedge Clk) if (WEN) rf[RW] <= busW;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int xfer_cyc = 0;
  bit send_to = 1'b0;

  typedef struct {
    logic [7:0] res;
    logic       ovf;
    logic [2:0] rd;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;
    logic [7:0] res;
    logic       ovf;
  } ins_t;

  function automatic ins_t mk(input logic [2:0] op, input logic [2:0] rd,
                              input logic [2:0] rs, input logic [2:0] rt,
                              input logic [7:0] imm, input logic [7:0] res,
                              input logic ovf);
    ins_t t;
    t.op = op; t.rd = rd; t.rs = rs; t.rt = rt;
    t.imm = imm; t.res = res; t.ovf = ovf;
    return t;
  endfunction

  // Issue one instruction and push its expected write-back.
  task automatic send(input ins_t in);
    int guard = 0;
    exp_t e;
    send_to = 1'b0;
    @(negedge Clk);
    while (cpu.in_ready !== 1'b1 && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (cpu.in_ready !== 1'b1) send_to = 1'b1;
    cpu.in_valid = 1'b1;
    cpu.op  = in.op;
    cpu.rd  = in.rd;
    cpu.rs  = in.rs;
    cpu.rt  = in.rt;
    cpu.imm = in.imm;
    @(posedge Clk);
    xfer_cyc = cyc;
    #1 cpu.in_valid = 1'b0;
    e.res = in.res;
    e.ovf = in.ovf;
    e.rd  = in.rd;
    e.lat = (in.op == OP_MUL) ? 10 : 3;
    sb.push_back(e);
  endtask

  // Bounded wait for done; lat is the cycle number counted from the transfer edge.
  task automatic wait_done(output int lat, output bit to, output bit rdy_seen);
    bit got = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge Clk);
      if (cpu.in_ready === 1'b1) rdy_seen = 1'b1;
      if (cpu.done === 1'b1) begin
        lat = cyc - xfer_cyc;
        got = 1'b1;
      end
    end
    to = !got;
  endtask

  task automatic test_reset();
    cpu.in_valid = 1'b1;
    cpu.op = OP_LDI; cpu.rd = 3'd1; cpu.rs = 3'd0; cpu.rt = 3'd0; cpu.imm = 8'h55;
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if (cpu.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, expected 0", cpu.in_ready);
    end
    checks++;
    if ({WEN, RW, RX, RY, busW, cpu.done, cpu.ovf, cpu.result} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs: wen=%b rw=%0d rx=%0d ry=%0d busw=%h done=%b ovf=%b result=%h, expected all 0",
               WEN, RW, RX, RY, busW, cpu.done, cpu.ovf, cpu.result);
    end
    cpu.in_valid = 1'b0;
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (cpu.in_ready !== 1'b1 || cpu.done !== 1'b0 || WEN !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b done=%b wen=%b, expected 1 0 0",
               cpu.in_ready, cpu.done, WEN);
    end
  endtask

  task automatic test_ldi();
    ins_t prog[$];
    exp_t e;
    int lat;
    bit to, rdy;
    prog.push_back(mk(OP_LDI, 3'd1, 3'd0, 3'd0, 8'hAA, 8'hAA, 1'b0));
    prog.push_back(mk(OP_OR,  3'd4, 3'd1, 3'd0, 8'h00, 8'hAA, 1'b0));
    foreach (prog[i]) begin
      send(prog[i]);
      wait_done(lat, to, rdy);
      e = sb.pop_front();
      checks++;
      if (to || send_to ||
          {cpu.result, cpu.ovf, WEN, RW, busW} !== {e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res}) begin
        errors++;
        $display("FAIL ldi[%0d] wb: got res=%h ovf=%b wen=%b rw=%0d busw=%h timeout=%b, expected res=%h ovf=%b wen=%b rw=%0d busw=%h",
                 i, cpu.result, cpu.ovf, WEN, RW, busW, to, e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL ldi[%0d] latency: done in cycle %0d, expected %0d", i, lat, e.lat);
      end
    end
    checks++;
    if (rf[1] !== 8'hAA) begin
      errors++;
      $display("FAIL ldi_regfile: reg1=%h, expected aa", rf[1]);
    end
  endtask

  task automatic test_alu();
    ins_t prog[$];
    exp_t e;
    int lat;
    bit to, rdy;
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h7F, 8'h7F, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd3, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0));
    prog.push_back(mk(OP_ADD, 3'd4, 3'd2, 3'd3, 8'h00, 8'h80, 1'b1));
    prog.push_back(mk(OP_SUB, 3'd5, 3'd3, 3'd2, 8'h00, 8'h82, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'h80, 8'h80, 1'b0));
    prog.push_back(mk(OP_SUB, 3'd5, 3'd2, 3'd3, 8'h00, 8'h7F, 1'b1));
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0));
    prog.push_back(mk(OP_SLT, 3'd7, 3'd2, 3'd3, 8'h00, 8'h01, 1'b0));
    prog.push_back(mk(OP_SLT, 3'd7, 3'd3, 3'd2, 8'h00, 8'h00, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hCC, 8'hCC, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd3, 3'd0, 3'd0, 8'hAA, 8'hAA, 1'b0));
    prog.push_back(mk(OP_AND, 3'd4, 3'd2, 3'd3, 8'h00, 8'h88, 1'b0));
    prog.push_back(mk(OP_OR,  3'd5, 3'd2, 3'd3, 8'h00, 8'hEE, 1'b0));
    prog.push_back(mk(OP_XOR, 3'd6, 3'd2, 3'd3, 8'h00, 8'h66, 1'b0));
    foreach (prog[i]) begin
      send(prog[i]);
      wait_done(lat, to, rdy);
      e = sb.pop_front();
      checks++;
      if (to || send_to ||
          {cpu.result, cpu.ovf, WEN, RW, busW} !== {e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res}) begin
        errors++;
        $display("FAIL alu[%0d] wb: got res=%h ovf=%b wen=%b rw=%0d busw=%h timeout=%b, expected res=%h ovf=%b wen=%b rw=%0d busw=%h",
                 i, cpu.result, cpu.ovf, WEN, RW, busW, to, e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL alu[%0d] latency: done in cycle %0d, expected %0d", i, lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    ins_t prog[$];
    exp_t e;
    int lat;
    bit to, rdy;
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'd13, 8'd13, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd3, 3'd0, 3'd0, 8'd11, 8'd11, 1'b0));
    prog.push_back(mk(OP_MUL, 3'd6, 3'd2, 3'd3, 8'h00, 8'h8F, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd3, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0));
    prog.push_back(mk(OP_MUL, 3'd1, 3'd2, 3'd3, 8'h00, 8'h01, 1'b0));
    prog.push_back(mk(OP_MUL, 3'd7, 3'd2, 3'd0, 8'h00, 8'h00, 1'b0));
    foreach (prog[i]) begin
      send(prog[i]);
      wait_done(lat, to, rdy);
      e = sb.pop_front();
      checks++;
      if (to || send_to ||
          {cpu.result, cpu.ovf, WEN, RW, busW} !== {e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res}) begin
        errors++;
        $display("FAIL mul[%0d] wb: got res=%h ovf=%b wen=%b rw=%0d busw=%h timeout=%b, expected res=%h ovf=%b wen=%b rw=%0d busw=%h",
                 i, cpu.result, cpu.ovf, WEN, RW, busW, to, e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL mul[%0d] latency: done in cycle %0d, expected %0d", i, lat, e.lat);
      end
      if (prog[i].op == OP_MUL) begin
        checks++;
        if (rdy) begin
          errors++;
          $display("FAIL mul[%0d] busy_ready: in_ready=1 seen in cycles 1..%0d, expected 0", i, lat);
        end
        @(negedge Clk);
        checks++;
        if (cpu.in_ready !== 1'b1 || cpu.done !== 1'b0) begin
          errors++;
          $display("FAIL mul[%0d] after_wb: in_ready=%b done=%b, expected 1 0", i, cpu.in_ready, cpu.done);
        end
      end
    end
  endtask

  task automatic test_r0();
    ins_t prog[$];
    exp_t e;
    int lat;
    bit to, rdy;
    prog.push_back(mk(OP_LDI, 3'd2, 3'd0, 3'd0, 8'hCC, 8'hCC, 1'b0));
    prog.push_back(mk(OP_LDI, 3'd3, 3'd0, 3'd0, 8'hAA, 8'hAA, 1'b0));
    prog.push_back(mk(OP_ADD, 3'd0, 3'd2, 3'd3, 8'h00, 8'h76, 1'b1));
    prog.push_back(mk(OP_OR,  3'd5, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0));
    foreach (prog[i]) begin
      send(prog[i]);
      wait_done(lat, to, rdy);
      e = sb.pop_front();
      checks++;
      if (to || send_to ||
          {cpu.result, cpu.ovf, WEN, RW, busW} !== {e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res}) begin
        errors++;
        $display("FAIL r0[%0d] wb: got res=%h ovf=%b wen=%b rw=%0d busw=%h timeout=%b, expected res=%h ovf=%b wen=%b rw=%0d busw=%h",
                 i, cpu.result, cpu.ovf, WEN, RW, busW, to, e.res, e.ovf, (e.rd != 3'd0), e.rd, e.res);
      end
      checks++;
      if (lat !== e.lat) begin
        errors++;
        $display("FAIL r0[%0d] latency: done in cycle %0d, expected %0d", i, lat, e.lat);
      end
    end
    @(negedge Clk);
    checks++;
    if (cpu.done !== 1'b0 || rf[0] !== 8'h00) begin
      errors++;
      $display("FAIL r0_hold: done=%b reg0=%h, expected 0 00", cpu.done, rf[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    exp_t e;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (cpu.done === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b done: unexpected done at step %0d", k);
        end else begin
          e = sb.pop_front();
          if ({cpu.result, WEN, RW, busW} !== {e.res, 1'b1, e.rd, e.res}) begin
            errors++;
            $display("FAIL b2b wb: got res=%h wen=%b rw=%0d busw=%h, expected res=%h wen=1 rw=%0d busw=%h",
                     cpu.result, WEN, RW, busW, e.res, e.rd, e.res);
          end
        end
      end
      if (k < 13) begin
        checks++;
        if (cpu.in_ready !== (k % 4 == 0)) begin
          errors++;
          $display("FAIL b2b ready: step %0d in_ready=%b, expected %b", k, cpu.in_ready, (k % 4 == 0));
        end
      end
      cpu.in_valid = (k < 13);
      cpu.op  = OP_LDI;
      cpu.rd  = 3'd1;
      cpu.rs  = 3'd0;
      cpu.rt  = 3'd0;
      cpu.imm = 8'h10 + n[7:0];
      if (cpu.in_valid && cpu.in_ready) begin
        e.res = cpu.imm; e.ovf = 1'b0; e.rd = 3'd1; e.lat = 3;
        sb.push_back(e);
        n++;
      end
    end
    cpu.in_valid = 1'b0;
    checks++;
    if (n != 4 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b count: accepted=%0d pending=%0d, expected 4 0", n, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    bit bad = 1'b0;
    send(mk(OP_MUL, 3'd6, 3'd2, 3'd3, 8'h00, 8'h00, 1'b0));
    @(negedge Clk);
    while ((cyc - xfer_cyc) < 5 && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if ({WEN, RW, RX, RY, busW, cpu.done, cpu.ovf, cpu.result, cpu.in_ready} !== 31'd0) begin
      errors++;
      $display("FAIL midreset_outputs: wen=%b rw=%0d rx=%0d ry=%0d busw=%h done=%b ovf=%b result=%h rdy=%b, expected all 0",
               WEN, RW, RX, RY, busW, cpu.done, cpu.ovf, cpu.result, cpu.in_ready);
    end
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (cpu.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready: in_ready=%b, expected 1", cpu.in_ready);
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (WEN !== 1'b0 || cpu.done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || rf[6] !== 8'h8F) begin
      errors++;
      $display("FAIL midreset_nowrite: stray write/done=%b reg6=%h, expected 0 8f", bad, rf[6]);
    end
    sb.delete();
  endtask

  initial begin
    cpu.in_valid = 1'b0;
    cpu.op  = 3'd0;
    cpu.rd  = 3'd0;
    cpu.rs  = 3'd0;
    cpu.rt  = 3'd0;
    cpu.imm = 8'h00;
    test_reset();
    test_ldi();
    test_alu();
    test_mul();
    test_r0();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_sequencer.md
# calc_sequencer

Multi-cycle ALU sequencer that drives the 8×8 `register_file` as its sole upstream master.
- Accepts one three-address instruction at a time over a valid/ready handshake.
- Reads both source operands through the file's two combinational read ports, executes the operation (multiply takes 8 iterative cycles), then writes the result back through the file's write port.
- Completes the simple-calculator datapath: this block owns all register-file port control.

## Interface
Parameters:
- `DW`, 8, datapath width; must equal the register-file word width.
- `AW`, 3, register index width (8 registers).

Ports:
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  sequencer can accept; high only in IDLE with `Rst`=0.
- `op`  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 MUL (low 8 bits), 7 LDI.
- `rd`, `rs`, `rt`  in  AW each  destination, source A, source B.
- `imm`  in  DW  immediate, used by LDI only.
- `RX`, `RY`  out  AW each  register-file read addresses.
- `busX`, `busY`  in  DW each  register-file read data (combinational).
- `WEN`  out  1  register-file write enable.
- `RW`  out  AW  register-file write address.
- `busW`  out  DW  register-file write data.
- `done`  out  1  one-cycle pulse in the WB cycle.
- `result`  out  DW  result, valid while `done`=1; holds until the next WB.
- `ovf`  out  1  signed overflow of ADD/SUB; 0 for all other ops; valid with `done`.

## Operation
Handshake and capture:
- Transfer occurs on a rising edge with `in_valid` && `in_ready`.
- `op`, `rd`, `rs`, `rt` and `imm` are captured into internal registers at the transfer edge.
- Inputs are ignored at all other times.

FSM states: IDLE, READ, EXEC, MUL, WB.
- IDLE → READ on transfer.
- READ: drive `RX`=rs and `RY`=rt; capture `busX`→A and `busY`→B at the end of the cycle. Go to MUL if op=6, else EXEC.
- EXEC: compute the result and latch it. Go to WB.
  - ADD/SUB wrap modulo 2^8.
  - `ovf` = operand signs equal to each other (ADD) or different (SUB), and the result sign differs from A.
  - SLT gives 8'd1 if $signed(A) < $signed(B), else 8'd0.
  - LDI gives `imm`; its A/B values are read but unused.
- MUL: shift-add with an 8-bit iteration counter.
  - Each cycle: if B[0], acc += A; then A <<= 1, B >>= 1.
  - Exactly 8 MUL cycles, then go to WB with result = acc[7:0].
- WB: `WEN`=1, `RW`=rd, `busW`=result, `done`=1, `result` updated. Go to IDLE.
  - If rd=0, `WEN` stays 0 (register 0 is constant zero); `done` still pulses.

Output defaults (all states other than those above):
- `WEN`=0, `RW`=0, `busW`=0.
- `RX`, `RY` = 0 outside READ.

Reset (`Rst`=1 at an edge):
- State → IDLE.
- `WEN`, `RW`, `RX`, `RY`, `busW`, `done`, `ovf`, `result`, acc and counter all → 0.
- `in_ready`=0 while `Rst` is high, 1 on the first cycle after release.
- Reset mid-operation aborts with no write, including reset in the WB cycle: the WB outputs are replaced by zeros.

## Timing
- Cycle 0 is the transfer edge.

Non-MUL ops:
- READ is cycle 1, EXEC cycle 2, WB cycle 3.
- The register-file write takes effect at the end of cycle 3.
- `in_ready` returns high in cycle 4.
- Minimum issue interval is 4 cycles.

MUL:
- READ 1, MUL 2–9, WB 10.
- `in_ready` high in cycle 11.

Read-after-write:
- The next instruction's READ occurs at least 2 cycles after the prior WB edge.
- No forwarding is needed; a consumer of the prior `rd` sees the new value.

Ports:
- All outputs are registered, except `in_ready`, which is decoded from state and `Rst`.
- `busX`/`busY` are sampled only at the end of READ; changes at other times have no effect.

## Test plan
- Reset, then LDI rd=1 imm=8'hAA → `done` at cycle 3, `WEN`=1, `RW`=1, `busW`=8'hAA; a later read of reg 1 returns 8'hAA.
- LDI r2=8'h7F, LDI r3=8'h01, ADD r4=r2+r3 → result 8'h80, `ovf`=1; SUB r5=r3-r2 → 8'h82, `ovf`=0.
- LDI r2=8'd13, r3=8'd11, MUL r6 → `done` exactly 10 cycles after transfer, result 8'h8F (143); `in_ready` low during cycles 1–10.
- SLT r7=r2(8'hFF),r3(8'h01) → 8'd1; swapped operands → 8'd0. AND/OR/XOR on 8'hCC and 8'hAA → 8'h88, 8'hEE, 8'h66.
- ADD rd=0 → `done` pulses, `WEN`=0, reg 0 still reads 8'h00. `in_valid` held high continuously → one instruction per 4 cycles, and none accepted while busy.
- Assert `Rst` in MUL cycle 5 → no `WEN` pulse and all outputs 0 the next cycle; `in_ready`=1 the cycle after release; the destination register is unchanged.
